// File: rtl/muldiv_unit_pkg.sv
// Shared types and helpers for the RV64M multiply/divide unit and its users.
package muldiv_unit_pkg;

    // Width of the 32-bit "*W" operand forms.
    localparam int WORD_W = 32;

    typedef enum logic [3:0] {
        MUL, MULH, MULHSU, MULHU,
        DIV, DIVU, REM, REMU,
        MULW, DIVW, DIVUW, REMW, REMUW
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE, ST_MUL, ST_DIV, ST_DONE
    } md_state_t;

    // Decode control bundle; mul_div_en steers an instruction to the multi-cycle unit.
    typedef struct packed {
        logic       mul_div_en;
        muldiv_op_t muldiv_op;
    } decode_ctrl_t;

    function automatic logic is_word(input muldiv_op_t op);
        return op inside {MULW, DIVW, DIVUW, REMW, REMUW};
    endfunction

    function automatic logic is_mul(input muldiv_op_t op);
        return op inside {MUL, MULH, MULHSU, MULHU, MULW};
    endfunction

    function automatic logic is_high(input muldiv_op_t op);
        return op inside {MULH, MULHSU, MULHU};
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return op inside {REM, REMU, REMW, REMUW};
    endfunction

    // rs1 is treated as two's complement for these ops.
    function automatic logic op_a_signed(input muldiv_op_t op);
        return op inside {MUL, MULH, MULHSU, MULW, DIV, REM, DIVW, REMW};
    endfunction

    // rs2 is treated as two's complement for these ops (MULHSU excluded).
    function automatic logic op_b_signed(input muldiv_op_t op);
        return op inside {MUL, MULH, MULW, DIV, REM, DIVW, REMW};
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring divider datapath: one subtract-compare step per enabled cycle.
// The dividend is pre-aligned so its most significant useful bit sits at the top.
module div_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient_next,
    output logic [XLEN-1:0] remainder_next
);

    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvs;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            fits;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted        = {rem, quo[XLEN-1]};
        diff           = shifted - {1'b0, dvs};
        fits           = ~diff[XLEN];
        remainder_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quotient_next  = {quo[XLEN-2:0], fits};
    end

    // Quotient shifts in from the bottom as dividend bits leave from the top.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (step) begin
            quo <= quotient_next;
            rem <= remainder_next;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV64M multiply/divide unit. Operands are converted to magnitudes
// on accept, iterated unsigned, and sign-corrected on the final iteration so
// the registered result is presented during the single DONE cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            in_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            exe_wait
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int ACC_W = 2 * XLEN;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    md_state_t         state;
    md_state_t         state_next;
    logic [CNT_W-1:0]  cnt;
    muldiv_op_t        op_q;
    logic              res_neg_q;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  mcand;
    logic [XLEN-1:0]   mplier;

    logic              word;
    logic [XLEN-1:0]   a_ext;
    logic [XLEN-1:0]   b_ext;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   min_val;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_val;
    logic [XLEN-1:0]   special_result;
    logic              res_neg;
    logic [CNT_W-1:0]  iter_count;
    logic [XLEN-1:0]   dividend;
    logic              accept;
    logic              last_iter;

    logic [ACC_W-1:0]  partial;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  prod;
    logic [XLEN-1:0]   mul_sel;
    logic [XLEN-1:0]   mul_result;
    logic [XLEN-1:0]   quotient_next;
    logic [XLEN-1:0]   remainder_next;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   div_result;

    // Decode the incoming request: operand extension, magnitudes, special cases.
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    always_comb begin
        word  = is_word(op);
        a_ext = a;
        b_ext = b;
        if (word) begin
            a_ext = op_a_signed(op) ? sext32(a[31:0]) : XLEN'(a[31:0]);
            b_ext = op_b_signed(op) ? sext32(b[31:0]) : XLEN'(b[31:0]);
        end
        a_neg   = op_a_signed(op) & a_ext[XLEN-1];
        b_neg   = op_b_signed(op) & b_ext[XLEN-1];
        mag_a   = a_neg ? -a_ext : a_ext;
        mag_b   = b_neg ? -b_ext : b_ext;
        min_val = word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};

        div_zero = ~is_mul(op) & (b_ext == '0);
        div_ovf  = ~is_mul(op) & op_b_signed(op) & (a_ext == min_val) & (b_ext == '1);
        special  = div_zero | div_ovf;
        // Zero divisor: q = all ones, r = dividend. Overflow: q = MIN, r = 0.
        if (div_zero)
            special_val = is_rem(op) ? a_ext : '1;
        else
            special_val = is_rem(op) ? '0 : a_ext;
        special_result = word ? sext32(special_val[31:0]) : special_val;

        // Remainder takes the dividend's sign; everything else the XOR of signs.
        res_neg = is_rem(op) ? a_neg : (a_neg ^ b_neg);
        if (is_mul(op))
            iter_count = CNT_W'((word ? WORD_W : XLEN) / MUL_STEP);
        else
            iter_count = CNT_W'(word ? WORD_W : XLEN);
        dividend = word ? (mag_a << (XLEN - WORD_W)) : mag_a;

        accept    = (state == ST_IDLE) & in_valid & ~flush;
        last_iter = (cnt == CNT_W'(1));
    end

    // Multiply step: add MUL_STEP shifted copies of the multiplicand, then finalize.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_STEP; i++)
            if (mplier[i])
                partial = partial + (mcand << i);
        acc_next   = acc + partial;
        prod       = res_neg_q ? -acc_next : acc_next;
        mul_sel    = is_high(op_q) ? prod[ACC_W-1:XLEN] : prod[XLEN-1:0];
        mul_result = is_word(op_q) ? sext32(mul_sel[31:0]) : mul_sel;
    end

    // Divide finalize: pick quotient or remainder from the last step, fix the sign.
    always_comb begin
        div_sel    = is_rem(op_q) ? remainder_next : quotient_next;
        div_sel    = res_neg_q ? -div_sel : div_sel;
        div_result = is_word(op_q) ? sext32(div_sel[31:0]) : div_sel;
    end

    div_iter #(
        .XLEN(XLEN)
    ) u_div_iter (
        .clk            (clk),
        .resetn         (resetn),
        .load           (accept),
        .step           (state == ST_DIV),
        .dividend       (dividend),
        .divisor        (mag_b),
        .quotient_next  (quotient_next),
        .remainder_next (remainder_next)
    );

    // State register.
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; flush overrides everything and returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = special ? ST_DONE : (is_mul(op) ? ST_MUL : ST_DIV);
            ST_MUL:  if (last_iter) state_next = ST_DONE;
            ST_DIV:  if (last_iter) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush)
            state_next = ST_IDLE;
    end

    // Handshake outputs; a flush in DONE suppresses the result strobe.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE) & ~flush;
        exe_wait  = in_valid & ~out_valid;
    end

    // Operand latch, iteration counter, multiply accumulator and result register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            op_q      <= MUL;
            res_neg_q <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            result    <= '0;
        end else if (accept) begin
            cnt       <= iter_count;
            op_q      <= op;
            res_neg_q <= res_neg;
            acc       <= '0;
            mcand     <= ACC_W'(mag_a);
            mplier    <= mag_b;
            if (special)
                result <= special_result;
        end else if (state == ST_MUL || state == ST_DIV) begin
            cnt <= cnt - CNT_W'(1);
            if (state == ST_MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
            end
            if (last_iter && !flush)
                result <= (state == ST_MUL) ? mul_result : div_result;
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV64M multiply/divide unit for the execute stage, used alongside the single-cycle ALU. It accepts one operation per handshake and iterates over `N` cycles, holding `exe_wait` high until the result is ready. It returns a 64-bit result in RISC-V semantics, including the 32-bit `*W` forms. It replaces the constant-zero `exe_wait` path for M-extension instructions.

## Interface
- `XLEN`, 64: operand/result width (32 or 64; `*W` ops legal only when 64).
- `MUL_STEP`, 4: multiplier bits retired per cycle; must divide 32.
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: op request; held stable with operands until `out_valid`.
- `op` in `muldiv_op_t`: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
- `a`, `b` in XLEN: rs1, rs2 values.
- `flush` in 1: abort current op.
- `in_ready` out 1: high only in IDLE.
- `out_valid` out 1: one-cycle result strobe.
- `result` out XLEN: valid when `out_valid`.
- `exe_wait` out 1: `in_valid & ~out_valid`; stall to the pipeline.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, `in_valid & ~flush`: latch op and operand magnitudes plus result-sign flags. Load counter with N, then go to MUL or DIV.
- Division special cases go IDLE→DONE directly:
  - Divisor 0: quotient all-ones, remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN, remainder 0.
  - Width for both is 32 for `*W` ops, else XLEN.
- MUL: unsigned shift-add of magnitudes, `MUL_STEP` bits per cycle, into a 2·XLEN accumulator; N = (W ? 32 : XLEN)/MUL_STEP.
- DIV: restoring, 1 quotient bit per cycle; N = W ? 32 : XLEN.
- Counter decrements each iteration; at 1, the next state is DONE.
- DONE: apply sign correction (two's complement when the sign flag is set) and select the result half:
  - MUL → low half.
  - MULH* → high half.
  - DIV* → quotient; REM* → remainder.
  - `*W` → low 32 bits sign-extended to 64.
- DONE: `out_valid`=1 for exactly one cycle, then IDLE. No back-pressure.
- Signedness:
  - MULHSU: `a` signed, `b` unsigned.
  - REM sign follows the dividend; DIV sign is the XOR of operand signs.
  - `*W` ops sign- or zero-extend the low 32 bits per op before magnitude conversion.
- `flush` in any state: IDLE next cycle. `out_valid` is forced to 0 in the flush cycle, even in DONE.
- `flush` with `in_valid` in IDLE: not accepted.
- `in_valid` in MUL/DIV/DONE: ignored (`in_ready`=0).

## Timing
- Reset (`resetn` low, async): state IDLE, counter 0, `out_valid` 0, `result` 0, `in_ready` 1; `exe_wait` follows `in_valid`.
- Accept at edge T (IDLE, `in_valid`). `out_valid` is high in cycle:
  - Special case: T+1.
  - MUL: T+N+1 (64-bit, default: T+17; MULW: T+9).
  - DIV: T+XLEN+1 (64-bit: T+65; DIVW: T+33).
- `in_ready` returns high the cycle after `out_valid`. Back-to-back ops therefore have a 1-cycle IDLE gap; the next accept can occur in that cycle.
- `result` is registered and stable only during `out_valid`.
- `resetn` asserted mid-operation: immediate IDLE; the partial result is discarded.

## Structure
- `muldiv_op_t` enum in the shared `pipes` package. Add a `MulDivEn` control bit to the decode control struct.
- Width helper constants go in `common`.
- One sub-module, `div_iter`, holds the restoring-divide datapath (remainder/quotient registers, one subtract-compare step per enable). The multiply datapath and FSM stay in `muldiv_unit`.

## Test plan
- MUL 7 × -3 (64-bit) → result 0xFFFFFFFFFFFFFFEB at T+17. `exe_wait` is high from T until that cycle.
- MULHU 0xFFFFFFFFFFFFFFFF × 0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE. Same operands with MULH → 0.
- DIV -7 / 2 → -3 and REM → -1 at T+65. DIVW 0x80000000 / -1 → 0xFFFFFFFF80000000 at T+1.
- DIVU 5 / 0 → 0xFFFFFFFFFFFFFFFF; REMU 5 / 0 → 5; both at T+1.
- `flush` asserted at T+10 of a DIV → no `out_valid`; `in_ready`=1 at T+11. A new MUL accepted there completes normally.
- `resetn` pulsed low mid-MUL, asynchronously between edges → `in_ready`=1 and `out_valid`=0 immediately. No stale result follows.
